mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, between the EX/MEM register and `wb_reg`. It issues loads and stores to the data-memory port through a req/ack handshake, steers byte lanes, and sign- or zero-extends load data. It stalls the pipeline while an access is outstanding and drives `rdm`/`regwritem` into `wb_reg`, inserting a bubble on every stall cycle.

## Interface
- `BIG_ENDIAN`, default 0: 0 selects little-endian lane mapping, 1 selects big-endian.
- `clk`  in  1  pipeline clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `aluoutm`  in  32  effective address / ALU result
- `writedatam`  in  32  store data (low bits significant)
- `memreadm`  in  1  load instruction in M
- `memwritem`  in  1  store instruction in M
- `memsizem`  in  2  00 byte, 01 half, 10 word (11 treated as word)
- `memsignedm`  in  1  1 = sign-extend load
- `regwritein`  in  1  regwrite from EX/MEM register
- `regwritem`  out  1  regwrite to `wb_reg`, forced 0 on stall/fault cycles
- `rdm`  out  32  aligned, extended load data to `wb_reg`
- `stallm`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- `adel`, `ades`  out  1  misaligned load / store fault pulse
- `dmem_req`  out  1  access request, held until ack
- `dmem_we`  out  1  1 = write
- `dmem_addr`  out  32  word address, bits [1:0] = 0
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_be`  out  4  byte enables
- `dmem_ack`  in  1  access complete; `dmem_rdata` valid same cycle
- `dmem_rdata`  in  32  read word

## Operation
- Access = (memreadm | memwritem). Load has priority if both set (memwritem ignored).
- Misaligned: half with addr[0]=1, word with addr[1:0]≠0. No request; `adel` (load) or `ades` (store) high for that one cycle; `regwritem`=0; `stallm`=0.
- Non-access instruction: combinational pass-through, `regwritem`=`regwritein`, no stall.
- FSM states IDLE, REQ, DONE:
  - IDLE: aligned access → `stallm`=1, `regwritem`=0; register addr/we/be/wdata, size, sign, byte offset; next REQ with `dmem_req`=1.
  - REQ: `stallm`=1, `regwritem`=0, bus outputs held stable. On `dmem_ack`: capture extended load data into `rdm`, drop `dmem_req`, go to DONE. Otherwise stay in REQ.
  - DONE: `stallm`=0, `regwritem`=`regwritein`, `rdm` valid; EX/MEM advances; next IDLE.
- Store lanes (LE): byte `be`=1<<addr[1:0], wdata = byte×4; half `be`=addr[1]?1100:0011, wdata = half×2; word `be`=1111. BIG_ENDIAN mirrors lane index (3−n).
- Load extract uses the same lane mapping; extend bit 7/15 if `memsignedm`, else zero-fill. Stores leave `rdm` unchanged.
- `dmem_ack` while not in REQ is ignored.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `rdm` = 0. Combinational outputs (`stallm`, `regwritem`, `adel`, `ades`) = 0 while `rst` high.
- Aligned access with ack on first REQ cycle: 3 cycles in M (IDLE, REQ, DONE), 2 stall cycles. Each extra wait cycle adds 1 stall.
- `dmem_req` rises the edge after IDLE detects the access and falls on the edge that samples `dmem_ack`.
- `rst` mid-REQ: request dropped immediately (async). Memory discards the transaction. No `rdm` update.
- `rdm` holds its value outside DONE.

## Structure
- `mips_pkg`: memsize encodings (`MEM_B`, `MEM_H`, `MEM_W`), FSM state enum, data width constant 32.
- Sub-module `dmem_lane`: combinational be/wdata generation and load extract/extend, parameterised by `BIG_ENDIAN`. `mem_stage` holds the FSM and registers.

## Test plan
- Word load 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF → stallm high 4 cycles, rdm=0xDEADBEEF, regwritem=1 only in DONE.
- lb addr 0x103 signed, rdata 0x80FF_FFFF → be=1000, rdm=0xFFFFFF80. lbu → rdm=0x00000080.
- sh addr 0x202, writedatam=0x1234ABCD → dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1.
- lw addr 0x101 → adel=1 one cycle, no dmem_req, stallm=0, regwritem=0. sh addr 0x003 → ades=1.
- rst asserted during REQ, ack arrives next cycle → dmem_req=0 at once, ack ignored, rdm stays 0.
- Back-to-back load then ALU op → ALU op passes with no stall the cycle after DONE. BIG_ENDIAN=1 lb addr 0x0 → be=1000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS memory-access stage: access sizes, M-stage FSM states
// and the alignment rule used for AdEL/AdES detection.
package mips_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    // Size 2'b11 falls into the word case on purpose.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   is_misaligned = 1'b0;
            MEM_H:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for the data-memory port: store byte enables / replicated write
// data, and load lane extraction with sign or zero extension.
module dmem_lane
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_off,
    input  logic [DATA_W-1:0] st_data,
    output logic [3:0]        st_be,
    output logic [DATA_W-1:0] st_wdata,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_off,
    input  logic              ld_signed,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    // Big-endian mirrors the lane index: lane 3-n is simply the bitwise inverse of n.
    logic [1:0]  st_lane;
    logic        st_hi_half;
    logic [1:0]  ld_lane;
    logic        ld_hi_half;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign st_lane    = BIG_ENDIAN ? ~st_off    : st_off;
    assign st_hi_half = BIG_ENDIAN ? ~st_off[1] : st_off[1];
    assign ld_lane    = BIG_ENDIAN ? ~ld_off    : ld_off;
    assign ld_hi_half = BIG_ENDIAN ? ~ld_off[1] : ld_off[1];

    assign ld_byte = ld_rdata[{ld_lane, 3'b000} +: 8];
    assign ld_half = ld_hi_half ? ld_rdata[31:16] : ld_rdata[15:0];

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            MEM_B: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_data[7:0]}};
            end
            MEM_H: begin
                st_be    = st_hi_half ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = ld_rdata;
        case (ld_size)
            MEM_B:   ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            MEM_H:   ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS M stage: req/ack data-memory access FSM with pipeline stall, misalignment
// faults and the load-result register feeding wb_reg.
module mem_stage
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] aluoutm,
    input  logic [DATA_W-1:0] writedatam,
    input  logic              memreadm,
    input  logic              memwritem,
    input  logic [1:0]        memsizem,
    input  logic              memsignedm,
    input  logic              regwritein,
    output logic              regwritem,
    output logic [DATA_W-1:0] rdm,
    output logic              stallm,
    output logic              adel,
    output logic              ades,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata
);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdm_q, rdm_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        off_q, off_d;
    logic              load_q, load_d;

    logic              access;
    logic              misaligned;
    logic [3:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_ldata;
    logic              stall_c;
    logic              regw_c;
    logic              adel_c;
    logic              ades_c;

    assign access     = memreadm | memwritem;
    assign misaligned = is_misaligned(memsizem, aluoutm[1:0]);

    // Store side is steered from the live EX/MEM fields; load side from the captured ones.
    dmem_lane #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_lane (
        .st_size  (memsizem),
        .st_off   (aluoutm[1:0]),
        .st_data  (writedatam),
        .st_be    (lane_be),
        .st_wdata (lane_wdata),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_signed(sign_q),
        .ld_rdata (dmem_rdata),
        .ld_data  (lane_ldata)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdm_d   = rdm_q;
        size_d  = size_q;
        sign_d  = sign_q;
        off_d   = off_q;
        load_d  = load_q;
        stall_c = 1'b0;
        regw_c  = regwritein;
        adel_c  = 1'b0;
        ades_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access && misaligned) begin
                    adel_c = memreadm;
                    ades_c = ~memreadm;
                    regw_c = 1'b0;
                end else if (access) begin
                    stall_c = 1'b1;
                    regw_c  = 1'b0;
                    req_d   = 1'b1;
                    we_d    = ~memreadm;
                    be_d    = lane_be;
                    addr_d  = {aluoutm[DATA_W-1:2], 2'b00};
                    wdata_d = lane_wdata;
                    size_d  = memsizem;
                    sign_d  = memsignedm;
                    off_d   = aluoutm[1:0];
                    load_d  = memreadm;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                regw_c  = 1'b0;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                    if (load_q) begin
                        rdm_d = lane_ldata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdm_q   <= '0;
            size_q  <= MEM_B;
            sign_q  <= 1'b0;
            off_q   <= 2'b00;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdm_q   <= rdm_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            load_q  <= load_d;
        end
    end

    // Combinational controls are forced quiet while reset is held.
    assign stallm     = stall_c & ~rst;
    assign regwritem  = regw_c & ~rst;
    assign adel       = adel_c & ~rst;
    assign ades       = ades_c & ~rst;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign rdm        = rdm_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of loads/stores/faults on a little-endian
// instance, plus reset, back-to-back and big-endian sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluoutm, writedatam, dmem_rdata;
    logic        memreadm, memwritem, memsignedm, regwritein, dmem_ack;
    logic [1:0]  memsizem;

    logic        regwritem, stallm, adel, ades, dmem_req, dmem_we;
    logic [31:0] rdm, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;

    logic        b_regwritem, b_stallm, b_adel, b_ades, b_dmem_req, b_dmem_we;
    logic [31:0] b_rdm, b_dmem_addr, b_dmem_wdata;
    logic [3:0]  b_dmem_be;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage #(.BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .aluoutm(aluoutm), .writedatam(writedatam),
        .memreadm(memreadm), .memwritem(memwritem), .memsizem(memsizem),
        .memsignedm(memsignedm), .regwritein(regwritein), .regwritem(regwritem),
        .rdm(rdm), .stallm(stallm), .adel(adel), .ades(ades), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    mem_stage #(.BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .aluoutm(aluoutm), .writedatam(writedatam),
        .memreadm(memreadm), .memwritem(memwritem), .memsizem(memsizem),
        .memsignedm(memsignedm), .regwritein(regwritein), .regwritem(b_regwritem),
        .rdm(b_rdm), .stallm(b_stallm), .adel(b_adel), .ades(b_ades), .dmem_req(b_dmem_req),
        .dmem_we(b_dmem_we), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
        .dmem_be(b_dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic        rwin;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          waits;
        logic        mis;
        logic        eadel;
        logic        eades;
        logic [3:0]  ebe;
        logic [31:0] eaddr;
        logic        ewe;
        logic [31:0] ewd;
        logic [31:0] erdm;
        int          estall;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                input logic sgn, input logic rwin, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata, input int waits,
                                input logic mis, input logic eadel, input logic eades,
                                input logic [3:0] ebe, input logic [31:0] eaddr, input logic ewe,
                                input logic [31:0] ewd, input logic [31:0] erdm, input int estall);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn; v.rwin = rwin;
        v.addr = addr; v.wd = wd; v.rdata = rdata; v.waits = waits;
        v.mis = mis; v.eadel = eadel; v.eades = eades; v.ebe = ebe; v.eaddr = eaddr;
        v.ewe = ewe; v.ewd = ewd; v.erdm = erdm; v.estall = estall;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        memreadm = 1'b0; memwritem = 1'b0; memsizem = 2'b00; memsignedm = 1'b0;
        regwritein = 1'b0; aluoutm = '0; writedatam = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    endtask

    // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle again.
    task automatic run_vec(input int idx, input vec_t v);
        int stalls;
        string tag;
        tag = $sformatf("v%0d", idx);
        memreadm = v.rd; memwritem = v.wr; memsizem = v.size; memsignedm = v.sgn;
        regwritein = v.rwin; aluoutm = v.addr; writedatam = v.wd; dmem_rdata = v.rdata;
        dmem_ack = 1'b0;
        #1;
        if (v.mis) begin
            chk({tag, " adel"}, 32'(adel), 32'(v.eadel));
            chk({tag, " ades"}, 32'(ades), 32'(v.eades));
            chk({tag, " stallm"}, 32'(stallm), 32'd0);
            chk({tag, " regwritem"}, 32'(regwritem), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk({tag, " no dmem_req"}, 32'(dmem_req), 32'd0);
            chk({tag, " rdm kept"}, rdm, v.erdm);
            idle_inputs();
            @(posedge clk);
            @(negedge clk);
            return;
        end
        chk({tag, " idle regwritem"}, 32'(regwritem), 32'd0);
        stalls = stallm ? 1 : 0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " dmem_req"}, 32'(dmem_req), 32'd1);
        chk({tag, " dmem_addr"}, dmem_addr, v.eaddr);
        chk({tag, " dmem_be"}, 32'(dmem_be), 32'(v.ebe));
        chk({tag, " dmem_we"}, 32'(dmem_we), 32'(v.ewe));
        if (v.ewe) chk({tag, " dmem_wdata"}, dmem_wdata, v.ewd);
        for (int n = 0; n <= v.waits; n++) begin
            if (stallm) stalls++;
            if (n > 0) chk({tag, " req held"}, 32'(dmem_req), 32'd1);
            chk({tag, " req regwritem"}, 32'(regwritem), 32'd0);
            if (n == v.waits) dmem_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        #1;
        chk({tag, " done stallm"}, 32'(stallm), 32'd0);
        chk({tag, " done regwritem"}, 32'(regwritem), 32'(v.rwin));
        chk({tag, " done dmem_req"}, 32'(dmem_req), 32'd0);
        chk({tag, " rdm"}, rdm, v.erdm);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(v.estall));
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //              rd wr size   sg rw addr          wd            rdata        wt mis adl ads be       eaddr         we ewd           erdm          stall
        tbl[0]  = mk(1, 0, 2'b10, 0, 1, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 2, 0, 0, 0, 4'b1111, 32'h0000_0100, 0, 32'h0,        32'hDEADBEEF, 4);
        tbl[1]  = mk(1, 0, 2'b00, 1, 1, 32'h0000_0103, 32'h0,        32'h80FFFFFF, 0, 0, 0, 0, 4'b1000, 32'h0000_0100, 0, 32'h0,        32'hFFFFFF80, 2);
        tbl[2]  = mk(1, 0, 2'b00, 0, 1, 32'h0000_0103, 32'h0,        32'h80FFFFFF, 0, 0, 0, 0, 4'b1000, 32'h0000_0100, 0, 32'h0,        32'h00000080, 2);
        tbl[3]  = mk(0, 1, 2'b01, 0, 0, 32'h0000_0202, 32'h1234ABCD, 32'h0,        0, 0, 0, 0, 4'b1100, 32'h0000_0200, 1, 32'hABCDABCD, 32'h00000080, 2);
        tbl[4]  = mk(1, 0, 2'b01, 1, 1, 32'h0000_0102, 32'h0,        32'h80017FFF, 0, 0, 0, 0, 4'b1100, 32'h0000_0100, 0, 32'h0,        32'hFFFF8001, 2);
        tbl[5]  = mk(1, 0, 2'b01, 0, 1, 32'h0000_0100, 32'h0,        32'h8001F0F0, 0, 0, 0, 0, 4'b0011, 32'h0000_0100, 0, 32'h0,        32'h0000F0F0, 2);
        tbl[6]  = mk(0, 1, 2'b00, 0, 0, 32'h0000_0001, 32'h000000A5, 32'h0,        1, 0, 0, 0, 4'b0010, 32'h0000_0000, 1, 32'hA5A5A5A5, 32'h0000F0F0, 3);
        tbl[7]  = mk(0, 1, 2'b10, 0, 0, 32'h0000_0300, 32'hCAFEF00D, 32'h0,        0, 0, 0, 0, 4'b1111, 32'h0000_0300, 1, 32'hCAFEF00D, 32'h0000F0F0, 2);
        tbl[8]  = mk(1, 1, 2'b00, 0, 1, 32'h0000_0002, 32'h11111111, 32'h00AB0000, 0, 0, 0, 0, 4'b0100, 32'h0000_0000, 0, 32'h0,        32'h000000AB, 2);
        tbl[9]  = mk(1, 0, 2'b11, 0, 1, 32'h0000_0104, 32'h0,        32'h11223344, 0, 0, 0, 0, 4'b1111, 32'h0000_0104, 0, 32'h0,        32'h11223344, 2);
        tbl[10] = mk(1, 0, 2'b10, 0, 1, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 1, 0, 4'b0000, 32'h0,         0, 32'h0,        32'h11223344, 0);
        tbl[11] = mk(0, 1, 2'b01, 0, 0, 32'h0000_0003, 32'h5555AAAA, 32'h0,        0, 1, 0, 1, 4'b0000, 32'h0,         0, 32'h0,        32'h11223344, 0);
        tbl[12] = mk(1, 0, 2'b01, 1, 1, 32'h0000_00FE, 32'h0,        32'h7FFF0000, 0, 0, 0, 0, 4'b1100, 32'h0000_00FC, 0, 32'h0,        32'h00007FFF, 2);

        idle_inputs();
        rst = 1'b1;
        memreadm = 1'b1; regwritein = 1'b1;
        @(negedge clk);
        #1;
        chk("rst stallm", 32'(stallm), 32'd0);
        chk("rst regwritem", 32'(regwritem), 32'd0);
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'd0);
        chk("rst rdm", rdm, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        regwritein = 1'b1;
        #1;
        chk("alu passthru regwritem", 32'(regwritem), 32'd1);
        chk("alu passthru stallm", 32'(stallm), 32'd0);
        regwritein = 1'b0;
        #1;
        chk("alu passthru regwritem0", 32'(regwritem), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);

        // Load immediately followed by an ALU op: no stall the cycle after DONE.
        run_vec(100, tbl[5]);
        regwritein = 1'b1;
        #1;
        chk("b2b alu stallm", 32'(stallm), 32'd0);
        chk("b2b alu regwritem", 32'(regwritem), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b alu no req", 32'(dmem_req), 32'd0);
        idle_inputs();

        // Big-endian lane mirroring on a signed byte load at address 0.
        memreadm = 1'b1; memsizem = 2'b00; memsignedm = 1'b1; regwritein = 1'b1;
        aluoutm = 32'h0; dmem_rdata = 32'h80000000;
        @(posedge clk);
        @(negedge clk);
        chk("be dmem_be", 32'(b_dmem_be), 32'(4'b1000));
        chk("le dmem_be", 32'(dmem_be), 32'(4'b0001));
        dmem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("be rdm", b_rdm, 32'hFFFFFF80);
        chk("le rdm", rdm, 32'h00000000);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);

        // Reset while a request is outstanding; a late ack must be ignored.
        memreadm = 1'b1; memsizem = 2'b10; regwritein = 1'b1;
        aluoutm = 32'h100; dmem_rdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        chk("pre-rst dmem_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst mid-REQ dmem_req", 32'(dmem_req), 32'd0);
        chk("rst mid-REQ stallm", 32'(stallm), 32'd0);
        chk("rst mid-REQ rdm", rdm, 32'd0);
        memreadm = 1'b0; regwritein = 1'b0;
        dmem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("post-rst dmem_req", 32'(dmem_req), 32'd0);
        chk("post-rst rdm", rdm, 32'd0);
        chk("post-rst stallm", 32'(stallm), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
